// File: rtl/tick_sched_pkg.sv
// Shared state encoding, mode constants and helpers for the tick scheduler.
// The enum values are pinned so checkers can decode dbg_state directly.
package tick_sched_pkg;

  localparam logic [1:0] ST_IDLE_ENC  = 2'd0;
  localparam logic [1:0] ST_RUN_ENC   = 2'd1;
  localparam logic [1:0] ST_PAUSE_ENC = 2'd2;
  localparam logic [1:0] ST_DONE_ENC  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = ST_IDLE_ENC,
    ST_RUN   = ST_RUN_ENC,
    ST_PAUSE = ST_PAUSE_ENC,
    ST_DONE  = ST_DONE_ENC
  } state_e;

  localparam logic MODE_FREE    = 1'b0;
  localparam logic MODE_ONESHOT = 1'b1;

  function automatic logic is_busy(input state_e s);
    return (s == ST_RUN) || (s == ST_PAUSE);
  endfunction

endpackage

// File: rtl/tick_divider.sv
// Divider core: counts enabled cycles, emits a registered tick and toggles
// clkOut every div cycles. No control state of its own beyond the counter.
module tick_divider #(
  parameter int CNT_W = 26
) (
  input  logic             clkIn,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [CNT_W-1:0] div,
  output logic             tick,
  output logic             clkOut,
  output logic             wrap
);

  logic [CNT_W-1:0] r_cnt;
  logic             r_tick;
  logic             r_clk_out;
  logic [CNT_W-1:0] w_div_m1;

  // A divide value of 0 behaves as 1, so the terminal count never underflows.
  always_comb begin
    w_div_m1 = '0;
    if (div != '0) w_div_m1 = div - CNT_W'(1);
  end

  assign wrap = en && (r_cnt == w_div_m1);

  always_ff @(posedge clkIn or posedge rst) begin
    if (rst) begin
      r_cnt     <= '0;
      r_tick    <= 1'b0;
      r_clk_out <= 1'b0;
    end else if (clr) begin
      r_cnt     <= '0;
      r_tick    <= 1'b0;
      r_clk_out <= 1'b0;
    end else if (en) begin
      if (wrap) begin
        r_cnt     <= '0;
        r_tick    <= 1'b1;
        r_clk_out <= ~r_clk_out;
      end else begin
        r_cnt  <= r_cnt + CNT_W'(1);
        r_tick <= 1'b0;
      end
    end else begin
      r_tick <= 1'b0;
    end
  end

  assign tick   = r_tick;
  assign clkOut = r_clk_out;

endmodule

// File: rtl/tick_sched_ctrl.sv
// Programmable clock-enable scheduler: FSM, configuration registers and the
// one-shot tick counter wrapped around the tick_divider core.
module tick_sched_ctrl
  import tick_sched_pkg::*;
#(
  parameter int          CNT_W       = 26,
  parameter int          TICK_W      = 16,
  parameter int unsigned DEFAULT_DIV = 30000000
) (
  input  logic              clkIn,
  input  logic              rst,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CNT_W-1:0]  cfg_div,
  input  logic              cfg_mode,
  input  logic [TICK_W-1:0] cfg_count,
  input  logic              start,
  input  logic              pause,
  input  logic              stop,
  output logic              tick,
  output logic              clkOut,
  output logic              busy,
  output logic              done,
  output state_e            dbg_state
);

  // cfg handshake: a transfer happens on an edge where cfg_valid && cfg_ready;
  // cfg_ready depends only on state, and a held-off request has no effect.

  state_e            r_state;
  state_e            w_next;
  logic              r_busy;
  logic              r_done;
  logic [CNT_W-1:0]  r_div;
  logic              r_mode;
  logic [TICK_W-1:0] r_count;
  logic [TICK_W-1:0] r_tick_cnt;

  logic              w_launch;
  logic              w_abort;
  logic              w_en;
  logic              w_wrap;
  logic              w_last;
  logic              w_oneshot_tick;
  logic [TICK_W-1:0] w_count_eff;

  assign cfg_ready = (r_state == ST_IDLE) || (r_state == ST_DONE);

  // Counter advances only in RUN and only if neither stop nor pause wins this cycle.
  assign w_en           = (r_state == ST_RUN) && !stop && !pause;
  assign w_count_eff    = (r_count == '0) ? TICK_W'(1) : r_count;
  assign w_last         = (r_tick_cnt == (w_count_eff - TICK_W'(1)));
  assign w_oneshot_tick = w_wrap && (r_mode == MODE_ONESHOT);

  always_comb begin
    w_next   = r_state;
    w_launch = 1'b0;
    w_abort  = 1'b0;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (start && !stop && !pause) begin
          w_next   = ST_RUN;
          w_launch = 1'b1;
        end
      end
      ST_RUN: begin
        if (stop) begin
          w_next  = ST_IDLE;
          w_abort = 1'b1;
        end else if (pause) begin
          w_next = ST_PAUSE;
        end else if (w_oneshot_tick && w_last) begin
          w_next = ST_DONE;
        end
      end
      ST_PAUSE: begin
        if (stop) begin
          w_next  = ST_IDLE;
          w_abort = 1'b1;
        end else if (start && !pause) begin
          w_next = ST_RUN;
        end
      end
      default: begin
        w_next  = ST_IDLE;
        w_abort = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clkIn or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_busy  <= is_busy(w_next);
      r_done  <= (r_state == ST_RUN) && (w_next == ST_DONE);
    end
  end

  always_ff @(posedge clkIn or posedge rst) begin
    if (rst) begin
      r_div   <= CNT_W'(DEFAULT_DIV);
      r_mode  <= MODE_FREE;
      r_count <= TICK_W'(1);
    end else if (cfg_valid && cfg_ready) begin
      r_div   <= cfg_div;
      r_mode  <= cfg_mode;
      r_count <= cfg_count;
    end
  end

  // Free-run never advances this counter, so it stays at 0 there.
  always_ff @(posedge clkIn or posedge rst) begin
    if (rst) begin
      r_tick_cnt <= '0;
    end else if (w_launch || w_abort) begin
      r_tick_cnt <= '0;
    end else if (w_oneshot_tick) begin
      r_tick_cnt <= r_tick_cnt + TICK_W'(1);
    end
  end

  tick_divider #(
    .CNT_W (CNT_W)
  ) u_div (
    .clkIn  (clkIn),
    .rst    (rst),
    .en     (w_en),
    .clr    (w_launch || w_abort),
    .div    (r_div),
    .tick   (tick),
    .clkOut (clkOut),
    .wrap   (w_wrap)
  );

  assign busy      = r_busy;
  assign done      = r_done;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_tick_sched_ctrl.sv
// Directed bench for tick_sched_ctrl with a small default divide value.
module tb_tick_sched_ctrl;
  import tick_sched_pkg::*;

  localparam int CNT_W  = 26;
  localparam int TICK_W = 16;

  logic              clkIn;
  logic              rst;
  logic              cfg_valid;
  logic              cfg_ready;
  logic [CNT_W-1:0]  cfg_div;
  logic              cfg_mode;
  logic [TICK_W-1:0] cfg_count;
  logic              start;
  logic              pause;
  logic              stop;
  logic              tick;
  logic              clkOut;
  logic              busy;
  logic              done;
  state_e            dbg_state;

  int n_assert = 0;
  int n_fail   = 0;

  tick_sched_ctrl #(
    .CNT_W       (CNT_W),
    .TICK_W      (TICK_W),
    .DEFAULT_DIV (5)
  ) dut (
    .clkIn     (clkIn),
    .rst       (rst),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_div   (cfg_div),
    .cfg_mode  (cfg_mode),
    .cfg_count (cfg_count),
    .start     (start),
    .pause     (pause),
    .stop      (stop),
    .tick      (tick),
    .clkOut    (clkOut),
    .busy      (busy),
    .done      (done),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clkIn = 1'b0;
  always #5 clkIn = ~clkIn;

  task automatic step();
    @(posedge clkIn);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expect d-1 quiet cycles then one tick with the given clkOut/done values.
  task automatic expect_period(input int d, input logic exp_clk, input logic exp_done,
                               input string tag);
    for (int i = 1; i < d; i++) begin
      step();
      chk({tag, "_quiet"}, {31'd0, tick}, 32'd0);
      chk({tag, "_nodone"}, {31'd0, done}, 32'd0);
    end
    step();
    chk({tag, "_tick"}, {31'd0, tick}, 32'd1);
    chk({tag, "_clk"}, {31'd0, clkOut}, {31'd0, exp_clk});
    chk({tag, "_done"}, {31'd0, done}, {31'd0, exp_done});
  endtask

  task automatic send_cfg(input logic [CNT_W-1:0] d, input logic m,
                          input logic [TICK_W-1:0] n);
    cfg_valid = 1'b1;
    cfg_div   = d;
    cfg_mode  = m;
    cfg_count = n;
  endtask

  initial begin
    rst = 1'b0; cfg_valid = 1'b0; cfg_div = '0; cfg_mode = 1'b0; cfg_count = '0;
    start = 1'b0; pause = 1'b0; stop = 1'b0;
    #2 rst = 1'b1;
    #2;
    chk("rst_tick", {31'd0, tick}, 32'd0);
    chk("rst_clk", {31'd0, clkOut}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_ready", {31'd0, cfg_ready}, 32'd1);
    chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    step(); step();
    rst = 1'b0;

    // 1: default divide value (5), free-run
    start = 1'b1; step(); start = 1'b0;
    chk("t1_busy", {31'd0, busy}, 32'd1);
    chk("t1_state", 32'(dbg_state), 32'(ST_RUN));
    expect_period(5, 1'b1, 1'b0, "t1_p1");
    expect_period(5, 1'b0, 1'b0, "t1_p2");
    expect_period(5, 1'b1, 1'b0, "t1_p3");
    stop = 1'b1; step(); stop = 1'b0;
    chk("t1_stop_state", 32'(dbg_state), 32'(ST_IDLE));
    chk("t1_stop_clk", {31'd0, clkOut}, 32'd0);

    // 2: D=4 free-run
    send_cfg(4, MODE_FREE, 0); step(); cfg_valid = 1'b0;
    start = 1'b1; step(); start = 1'b0;
    expect_period(4, 1'b1, 1'b0, "t2_p1");
    chk("t2_busy", {31'd0, busy}, 32'd1);
    expect_period(4, 1'b0, 1'b0, "t2_p2");
    expect_period(4, 1'b1, 1'b0, "t2_p3");
    chk("t2_busy_end", {31'd0, busy}, 32'd1);
    stop = 1'b1; step(); stop = 1'b0;

    // 3: D=3 one-shot N=2, cfg and start in the same cycle
    send_cfg(3, MODE_ONESHOT, 2); start = 1'b1; step();
    cfg_valid = 1'b0; start = 1'b0;
    expect_period(3, 1'b1, 1'b0, "t3_p1");
    expect_period(3, 1'b0, 1'b1, "t3_p2");
    chk("t3_state", 32'(dbg_state), 32'(ST_DONE));
    chk("t3_busy", {31'd0, busy}, 32'd0);
    chk("t3_ready", {31'd0, cfg_ready}, 32'd1);
    step();
    chk("t3_hold_state", 32'(dbg_state), 32'(ST_DONE));
    chk("t3_hold_done", {31'd0, done}, 32'd0);
    chk("t3_hold_tick", {31'd0, tick}, 32'd0);
    chk("t3_hold_clk", {31'd0, clkOut}, 32'd0);

    // 4: D=6, pause at cnt=2 for 5 cycles, resume
    send_cfg(6, MODE_FREE, 0); start = 1'b1; step();
    cfg_valid = 1'b0; start = 1'b0;
    step(); step();
    pause = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t4_pause_tick", {31'd0, tick}, 32'd0);
      chk("t4_pause_state", 32'(dbg_state), 32'(ST_PAUSE));
      chk("t4_pause_busy", {31'd0, busy}, 32'd1);
    end
    pause = 1'b0; start = 1'b1; step(); start = 1'b0;
    chk("t4_resume_state", 32'(dbg_state), 32'(ST_RUN));
    expect_period(4, 1'b1, 1'b0, "t4_resume");

    // 5: start+stop together in RUN; cfg offered in RUN is held off
    start = 1'b1; stop = 1'b1; step(); start = 1'b0; stop = 1'b0;
    chk("t5_state", 32'(dbg_state), 32'(ST_IDLE));
    chk("t5_clk", {31'd0, clkOut}, 32'd0);
    chk("t5_done", {31'd0, done}, 32'd0);
    chk("t5_busy", {31'd0, busy}, 32'd0);
    start = 1'b1; step(); start = 1'b0;
    chk("t5_ready_run", {31'd0, cfg_ready}, 32'd0);
    send_cfg(2, MODE_ONESHOT, 1);
    expect_period(6, 1'b1, 1'b0, "t5_oldD");
    cfg_valid = 1'b0;

    // 6: asynchronous reset between edges while tick is high
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_tick", {31'd0, tick}, 32'd0);
    chk("t6_rst_clk", {31'd0, clkOut}, 32'd0);
    chk("t6_rst_busy", {31'd0, busy}, 32'd0);
    chk("t6_rst_state", 32'(dbg_state), 32'(ST_IDLE));
    #1 rst = 1'b0;
    start = 1'b1; step(); start = 1'b0;
    expect_period(5, 1'b1, 1'b0, "t6_default");
    stop = 1'b1; step(); stop = 1'b0;
    send_cfg(0, MODE_FREE, 0); start = 1'b1; step();
    cfg_valid = 1'b0; start = 1'b0;
    expect_period(1, 1'b1, 1'b0, "t6_d0_a");
    expect_period(1, 1'b0, 1'b0, "t6_d0_b");
    expect_period(1, 1'b1, 1'b0, "t6_d0_c");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
